// File: rtl/config_pkg.sv
// Shared configuration for the vectored interrupt controller: sizes, CSR map,
// return marker and the CSR op encoding used by the decoder.
package config_pkg;

  localparam int VecSize       = 8;
  localparam int PrioWidth     = 3;
  localparam int IMemAddrWidth = 16;
  localparam int VecIdxWidth   = (VecSize > 1) ? $clog2(VecSize) : 1;

  typedef logic [11:0]              csr_addr_t;
  typedef logic [IMemAddrWidth-1:0] imem_addr_t;
  typedef logic [VecIdxWidth-1:0]   vec_idx_t;
  typedef logic [PrioWidth-1:0]     prio_t;

  localparam csr_addr_t  CsrBase    = 12'hB00;
  localparam csr_addr_t  CsrVecBase = 12'hB20;
  localparam csr_addr_t  CsrThresh  = 12'hB40;
  localparam imem_addr_t ReturnAddr = '1;

  // funct3 encoding of the Zicsr instructions; bit 2 selects the immediate form
  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_t;

  typedef struct packed {
    prio_t prio;
    logic  enable;
    logic  pending;
  } clic_entry_t;

  function automatic prio_t prio_max(input prio_t a, input prio_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clic_arbiter.sv
// Combinational tournament tree picking the highest-priority requesting vector;
// on equal priority the left (lower-index) subtree wins.
module clic_arbiter #(
  parameter int VecSize   = 8,
  parameter int PrioWidth = 3,
  parameter int IdxWidth  = (VecSize > 1) ? $clog2(VecSize) : 1
) (
  input  logic [VecSize-1:0]                req_i,
  input  logic [VecSize-1:0][PrioWidth-1:0] prio_i,
  output logic                              valid_o,
  output logic [IdxWidth-1:0]               idx_o,
  output logic [PrioWidth-1:0]              prio_o
);

  localparam int Leaves = 2 ** IdxWidth;

  logic                 node_v [1:2*Leaves-1];
  logic [PrioWidth-1:0] node_p [1:2*Leaves-1];
  logic [IdxWidth-1:0]  node_i [1:2*Leaves-1];

  generate
    for (genvar gi = 0; gi < Leaves; gi++) begin : g_leaf
      if (gi < VecSize) begin : g_real
        assign node_v[Leaves+gi] = req_i[gi];
        assign node_p[Leaves+gi] = prio_i[gi];
        assign node_i[Leaves+gi] = IdxWidth'(gi);
      end else begin : g_pad
        assign node_v[Leaves+gi] = 1'b0;
        assign node_p[Leaves+gi] = '0;
        assign node_i[Leaves+gi] = '0;
      end
    end

    for (genvar gi = 1; gi < Leaves; gi++) begin : g_node
      logic pick_right;
      // right side only wins with a strictly higher priority
      assign pick_right = node_v[2*gi+1] &
                          (~node_v[2*gi] | (node_p[2*gi+1] > node_p[2*gi]));
      assign node_v[gi] = node_v[2*gi] | node_v[2*gi+1];
      assign node_p[gi] = pick_right ? node_p[2*gi+1] : node_p[2*gi];
      assign node_i[gi] = pick_right ? node_i[2*gi+1] : node_i[2*gi];
    end
  endgenerate

  assign valid_o = node_v[1];
  assign idx_o   = node_i[1];
  assign prio_o  = node_p[1];

endmodule

// File: rtl/n_clic_vec.sv
// Vectored nested interrupt controller: redirects the next PC on interrupt
// entry, nested return (pop) and tail-chaining, with a CSR-mapped vector table.
module n_clic_vec
  import config_pkg::*;
#(
  parameter int        VecSize    = config_pkg::VecSize,
  parameter int        PrioWidth  = config_pkg::PrioWidth,
  parameter csr_addr_t CsrBase    = config_pkg::CsrBase,
  parameter csr_addr_t CsrVecBase = config_pkg::CsrVecBase,
  parameter csr_addr_t CsrThresh  = config_pkg::CsrThresh
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     csr_enable,
  input  csr_addr_t                csr_addr,
  input  csr_op_t                  csr_op,
  input  logic [4:0]               rs1_zimm,
  input  logic [31:0]              rs1_data,
  input  logic [VecSize-1:0]       irq,
  input  logic [IMemAddrWidth-1:0] pc_in,
  output logic [IMemAddrWidth-1:0] pc_out,
  output logic [31:0]              csr_out,
  output logic [PrioWidth-1:0]     level_out
);

  localparam int IdxWidth = (VecSize > 1) ? $clog2(VecSize) : 1;
  localparam int Depth    = 2 ** PrioWidth - 1;
  localparam int WrWidth  = (IMemAddrWidth > PrioWidth + 2) ? IMemAddrWidth : PrioWidth + 2;

  logic [VecSize-1:0]                    irq_q;
  logic [VecSize-1:0]                    pend_q, pend_d, en_q, en_d;
  logic [VecSize-1:0][PrioWidth-1:0]     prio_q, prio_d;
  logic [VecSize-1:0][IMemAddrWidth-1:0] handler_q, handler_d;
  logic [PrioWidth-1:0]                  thresh_q, thresh_d;
  logic [PrioWidth-1:0]                  level_q, level_d;
  logic [PrioWidth-1:0]                  sp_q, sp_d;
  logic [IMemAddrWidth-1:0]              stack_pc_q  [Depth];
  logic [PrioWidth-1:0]                  stack_lvl_q [Depth];

  // ---------------- CSR access ----------------
  csr_addr_t          ctrl_off, hand_off;
  logic [VecSize-1:0] ctrl_sel, hand_sel;
  logic               thresh_sel;
  logic [2:0]         op_bits;
  logic [31:0]        csr_src;
  logic [WrWidth-1:0] csr_new;
  logic               csr_wr;

  assign ctrl_off   = csr_addr - CsrBase;
  assign hand_off   = csr_addr - CsrVecBase;
  assign thresh_sel = (csr_addr == CsrThresh);
  assign op_bits    = csr_op;
  assign csr_src    = op_bits[2] ? {27'd0, rs1_zimm} : rs1_data;

  generate
    for (genvar gi = 0; gi < VecSize; gi++) begin : g_dec
      assign ctrl_sel[gi] = (ctrl_off == 12'(gi));
      assign hand_sel[gi] = (hand_off == 12'(gi));
    end
  endgenerate

  always_comb begin
    csr_out = '0;
    for (int i = 0; i < VecSize; i++) begin
      if (ctrl_sel[i]) csr_out = 32'({prio_q[i], en_q[i], pend_q[i]});
      if (hand_sel[i]) csr_out = 32'(handler_q[i]);
    end
    if (thresh_sel) csr_out = 32'(thresh_q);
  end

  // set/clear with a zero source are pure reads
  always_comb begin
    csr_new = csr_out[WrWidth-1:0];
    csr_wr  = 1'b0;
    case (op_bits[1:0])
      2'b01: begin
        csr_new = csr_src[WrWidth-1:0];
        csr_wr  = csr_enable;
      end
      2'b10: begin
        csr_new = csr_out[WrWidth-1:0] | csr_src[WrWidth-1:0];
        csr_wr  = csr_enable & (|csr_src);
      end
      2'b11: begin
        csr_new = csr_out[WrWidth-1:0] & ~csr_src[WrWidth-1:0];
        csr_wr  = csr_enable & (|csr_src);
      end
      default: begin
        csr_new = csr_out[WrWidth-1:0];
        csr_wr  = 1'b0;
      end
    endcase
  end

  // ---------------- arbitration and PC redirect ----------------
  logic [VecSize-1:0]       edge_w;
  logic                     cand_v;
  logic [IdxWidth-1:0]      cand_idx;
  logic [PrioWidth-1:0]     cand_p;
  logic                     is_ret, stack_nz, tail, pop, entry, take;
  logic [PrioWidth-1:0]     top_idx, top_lvl, floor_ret, floor_run;
  logic [IMemAddrWidth-1:0] top_pc;

  assign edge_w = irq & ~irq_q;

  clic_arbiter #(
    .VecSize  (VecSize),
    .PrioWidth(PrioWidth),
    .IdxWidth (IdxWidth)
  ) u_arb (
    .req_i  (pend_q & en_q),
    .prio_i (prio_q),
    .valid_o(cand_v),
    .idx_o  (cand_idx),
    .prio_o (cand_p)
  );

  assign is_ret    = (pc_in == ReturnAddr);
  assign stack_nz  = (sp_q != '0);
  assign top_idx   = stack_nz ? sp_q - 1'b1 : '0;
  assign top_pc    = stack_pc_q[top_idx];
  assign top_lvl   = stack_lvl_q[top_idx];
  assign floor_ret = (top_lvl > thresh_q) ? top_lvl : thresh_q;
  assign floor_run = (level_q > thresh_q) ? level_q : thresh_q;

  assign tail  = is_ret & stack_nz & cand_v & (cand_p > floor_ret);
  assign pop   = is_ret & stack_nz & ~tail;
  assign entry = ~is_ret & cand_v & (cand_p > floor_run);
  assign take  = tail | entry;

  always_comb begin
    pc_out = pc_in;
    if (take)     pc_out = handler_q[cand_idx];
    else if (pop) pc_out = top_pc;
  end

  always_comb begin
    level_d = level_q;
    sp_d    = sp_q;
    if (take) level_d = cand_p;
    if (pop) begin
      level_d = top_lvl;
      sp_d    = sp_q - 1'b1;
    end
    if (entry) sp_d = sp_q + 1'b1;
  end

  // CSR write first, then the entry clear, then an edge re-sets pending
  always_comb begin
    pend_d    = pend_q;
    en_d      = en_q;
    prio_d    = prio_q;
    handler_d = handler_q;
    thresh_d  = thresh_q;
    for (int i = 0; i < VecSize; i++) begin
      if (csr_wr && ctrl_sel[i]) begin
        pend_d[i] = csr_new[0];
        en_d[i]   = csr_new[1];
        prio_d[i] = csr_new[PrioWidth+1:2];
      end
      if (csr_wr && hand_sel[i]) handler_d[i] = csr_new[IMemAddrWidth-1:0];
      if (take && (cand_idx == IdxWidth'(i))) pend_d[i] = 1'b0;
      if (edge_w[i]) pend_d[i] = 1'b1;
    end
    if (csr_wr && thresh_sel) thresh_d = csr_new[PrioWidth-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q     <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      prio_q    <= '0;
      handler_q <= '0;
      thresh_q  <= '0;
      level_q   <= '0;
      sp_q      <= '0;
    end else begin
      irq_q     <= irq;
      pend_q    <= pend_d;
      en_q      <= en_d;
      prio_q    <= prio_d;
      handler_q <= handler_d;
      thresh_q  <= thresh_d;
      level_q   <= level_d;
      sp_q      <= sp_d;
    end
  end

  // Stack contents need no reset; only entries below the pointer are ever read.
  always_ff @(posedge clk) begin
    if (!reset && entry) begin
      stack_pc_q[sp_q]  <= pc_in;
      stack_lvl_q[sp_q] <= level_q;
    end
  end

  assign level_out = level_q;

endmodule
